// File: rtl/sbox_sweep_checker.sv
// Sweeps every WIDTH-bit input through an external S-box and reports collisions and fixed points.
// Optional SBOX_SWEEP_LUT_EN adds a captured-output table with a registered read port.
module sbox_sweep_checker #(
  parameter int WIDTH    = 6,
  parameter int SBOX_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] sbox_x,
  input  logic [WIDTH-1:0] sbox_y,
  output logic             busy,
  output logic             done,
  output logic             is_perm,
  output logic [WIDTH:0]   collision_cnt,
  output logic [WIDTH:0]   fixed_cnt
`ifdef SBOX_SWEEP_LUT_EN
  ,
  input  logic [WIDTH-1:0] lut_addr,
  output logic [WIDTH-1:0] lut_data
`endif
);

  localparam int N = 1 << WIDTH;
  localparam logic [WIDTH-1:0] X_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] X_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sbox_x_reg;
  logic [N-1:0]     seen_reg;
  logic [WIDTH:0]   coll_reg;
  logic [WIDTH:0]   fixed_reg;
  logic             is_perm_reg;

  logic             cap_valid;
  logic [WIDTH-1:0] cap_tag;
  logic             hit;
  logic             fixed_hit;
  logic             finish;
  logic [WIDTH:0]   coll_next;
  logic [WIDTH:0]   fixed_next;

  // Capture tag lines up with the S-box output: either the live input or a delayed copy of it.
  generate
    if (SBOX_LAT == 0) begin : g_comb
      assign cap_valid = (state_reg == S_SWEEP);
      assign cap_tag   = sbox_x_reg;
    end else begin : g_pipe
      logic [SBOX_LAT-1:0] vld_reg;
      logic [WIDTH-1:0]    tag_reg [SBOX_LAT];
      for (genvar gi = 0; gi < SBOX_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          always_ff @(posedge clk) begin
            if (rst) begin
              vld_reg[gi] <= 1'b0;
              tag_reg[gi] <= '0;
            end else begin
              vld_reg[gi] <= (state_reg == S_SWEEP);
              tag_reg[gi] <= sbox_x_reg;
            end
          end
        end else begin : g_tail
          always_ff @(posedge clk) begin
            if (rst) begin
              vld_reg[gi] <= 1'b0;
              tag_reg[gi] <= '0;
            end else begin
              vld_reg[gi] <= vld_reg[gi-1];
              tag_reg[gi] <= tag_reg[gi-1];
            end
          end
        end
      end
      assign cap_valid = vld_reg[SBOX_LAT-1];
      assign cap_tag   = tag_reg[SBOX_LAT-1];
    end
  endgenerate

  assign hit        = cap_valid && seen_reg[sbox_y];
  assign fixed_hit  = cap_valid && (sbox_y == cap_tag);
  assign coll_next  = coll_reg + {{WIDTH{1'b0}}, hit};
  assign fixed_next = fixed_reg + {{WIDTH{1'b0}}, fixed_hit};
  // The sweep is complete once the last input's output has been captured.
  assign finish     = cap_valid && (cap_tag == X_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      sbox_x_reg  <= '0;
      seen_reg    <= '0;
      coll_reg    <= '0;
      fixed_reg   <= '0;
      is_perm_reg <= 1'b0;
    end else begin
      if (cap_valid) begin
        seen_reg[sbox_y] <= 1'b1;
        coll_reg         <= coll_next;
        fixed_reg        <= fixed_next;
      end
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_reg   <= S_SWEEP;
            sbox_x_reg  <= '0;
            seen_reg    <= '0;
            coll_reg    <= '0;
            fixed_reg   <= '0;
            is_perm_reg <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (sbox_x_reg != X_MAX) sbox_x_reg <= sbox_x_reg + X_ONE;
          if (finish) begin
            state_reg   <= S_DONE;
            is_perm_reg <= (coll_next == '0);
          end else if (sbox_x_reg == X_MAX) begin
            state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (finish) begin
            state_reg   <= S_DONE;
            is_perm_reg <= (coll_next == '0);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef SBOX_SWEEP_LUT_EN
  logic [WIDTH-1:0] lut_mem [N];
  logic [WIDTH-1:0] lut_data_reg;

  always_ff @(posedge clk) begin
    if (cap_valid) lut_mem[cap_tag] <= sbox_y;
  end

  always_ff @(posedge clk) begin
    if (rst) lut_data_reg <= '0;
    else     lut_data_reg <= lut_mem[lut_addr];
  end

  assign lut_data = lut_data_reg;
`endif

  assign sbox_x        = sbox_x_reg;
  assign busy          = (state_reg == S_SWEEP) || (state_reg == S_DRAIN);
  assign done          = (state_reg == S_DONE);
  assign is_perm       = is_perm_reg;
  assign collision_cnt = coll_reg;
  assign fixed_cnt     = fixed_reg;

endmodule

// File: tb/tb_sbox_sweep_checker.sv
// Bench for sbox_sweep_checker: one combinational and one 2-cycle S-box path, table-driven S-boxes.
// Reference counts come from value histograms of the S-box table.
module tb_sbox_sweep_checker;
  localparam int W = 6;
  localparam int N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start0, start2;
  logic [W-1:0] x0, y0, x2, y2, y2_d1, y2_d2;
  logic         busy0, done0, perm0, busy2, done2, perm2;
  logic [W:0]   coll0, fix0, coll2, fix2;
  logic [W-1:0] tab [N];
`ifdef SBOX_SWEEP_LUT_EN
  logic [W-1:0] lut_addr;
  logic [W-1:0] lut0, lut2;
`endif

  int errors = 0;
  int checks = 0;

  always_comb y0 = tab[x0];
  always @(posedge clk) begin
    y2_d1 <= tab[x2];
    y2_d2 <= y2_d1;
  end
  assign y2 = y2_d2;

  sbox_sweep_checker #(.WIDTH(W), .SBOX_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .sbox_x(x0), .sbox_y(y0),
    .busy(busy0), .done(done0), .is_perm(perm0),
    .collision_cnt(coll0), .fixed_cnt(fix0)
`ifdef SBOX_SWEEP_LUT_EN
    , .lut_addr(lut_addr), .lut_data(lut0)
`endif
  );

  sbox_sweep_checker #(.WIDTH(W), .SBOX_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sbox_x(x2), .sbox_y(y2),
    .busy(busy2), .done(done2), .is_perm(perm2),
    .collision_cnt(coll2), .fixed_cnt(fix2)
`ifdef SBOX_SWEEP_LUT_EN
    , .lut_addr(lut_addr), .lut_data(lut2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r;
    logic [5:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
    end
    return r;
  endfunction

  function automatic logic [5:0] gf_pow(input logic [5:0] a, input int e);
    logic [5:0] r;
    r = 6'd1;
    for (int i = 0; i < e; i++) r = gf_mul(r, a);
    return r;
  endfunction

  // Collisions = surplus occurrences of each output value; fixed = table entries equal to their index.
  task automatic model(output int coll, output int fixed);
    int hist [N];
    coll  = 0;
    fixed = 0;
    for (int v = 0; v < N; v++) hist[v] = 0;
    for (int x = 0; x < N; x++) begin
      hist[tab[x]]++;
      if (int'(tab[x]) == x) fixed++;
    end
    for (int v = 0; v < N; v++) if (hist[v] > 1) coll += hist[v] - 1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start2 = v;
  endtask

  task automatic sweep(input int sel, input string name, input int restart_at);
    int   exp_coll, exp_fix, cycles, lat;
    logic d;
    lat = (sel == 0) ? 0 : 2;
    model(exp_coll, exp_fix);
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    cycles = 0;
    check({name, " busy"}, (sel == 0) ? busy0 : busy2, 1);
    check({name, " perm_low"}, (sel == 0) ? perm0 : perm2, 0);
    d = (sel == 0) ? done0 : done2;
    while (!d && cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      set_start(sel, cycles == restart_at);
      d = (sel == 0) ? done0 : done2;
    end
    set_start(sel, 1'b0);
    check({name, " cycles"}, cycles, N + lat);
    check({name, " is_perm"}, (sel == 0) ? perm0 : perm2, (exp_coll == 0) ? 1 : 0);
    check({name, " coll"}, (sel == 0) ? coll0 : coll2, exp_coll);
    check({name, " fixed"}, (sel == 0) ? fix0 : fix2, exp_fix);
    $display("sweep %s lat=%0d cycles=%0d coll=%0d fixed=%0d exp_coll=%0d exp_fixed=%0d",
             name, lat, cycles, (sel == 0) ? coll0 : coll2, (sel == 0) ? fix0 : fix2,
             exp_coll, exp_fix);
  endtask

`ifdef SBOX_SWEEP_LUT_EN
  task automatic lut_read(input int sel, input logic [W-1:0] a, input logic [W-1:0] exp);
    lut_addr = a;
    @(posedge clk); #1;
    check("lut_data", (sel == 0) ? lut0 : lut2, exp);
    $display("lut dut%0d addr=%0d data=%0d exp=%0d", sel == 0 ? 0 : 2, a,
             (sel == 0) ? lut0 : lut2, exp);
  endtask
`endif

  task automatic shuffle_tab();
    logic [W-1:0] t;
    int j;
    for (int i = 0; i < N; i++) tab[i] = W'(i);
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = tab[i]; tab[i] = tab[j]; tab[j] = t;
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
`ifdef SBOX_SWEEP_LUT_EN
    lut_addr = '0;
`endif
    for (int i = 0; i < N; i++) tab[i] = W'(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst x0", x0, 0);
    check("rst busy0", busy0, 0);
    check("rst done0", done0, 0);
    check("rst perm0", perm0, 0);
    check("rst coll0", coll0, 0);
    check("rst fix0", fix0, 0);
    check("rst busy2", busy2, 0);
`ifdef SBOX_SWEEP_LUT_EN
    check("rst lut0", lut0, 0);
`endif
    $display("reset applied");

    sweep(0, "identity", -1);
    for (int i = 0; i < N; i++) tab[i] = '0;
    sweep(0, "zero", -1);
    for (int i = 0; i < N; i++) tab[i] = W'(i >> 1);
    sweep(0, "shr1", -1);
    for (int i = 0; i < N; i++) tab[i] = W'(i ^ 1);
    sweep(2, "xor1", -1);
`ifdef SBOX_SWEEP_LUT_EN
    lut_read(2, 6'd5, 6'd4);
`endif
    for (int i = 0; i < N; i++) tab[i] = gf_pow(W'(i), 52);
    sweep(0, "pow52", -1);
    sweep(2, "pow52_lat2", -1);
`ifdef SBOX_SWEEP_LUT_EN
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] a;
      a = W'($urandom_range(N - 1, 0));
      lut_read(0, a, tab[a]);
    end
`endif

    for (int r = 0; r < 4; r++) begin
      shuffle_tab();
      if (r[0]) for (int k = 0; k < 5; k++) tab[$urandom_range(N - 1, 0)] = W'($urandom);
      sweep(r % 2 == 0 ? 0 : 2, "random", -1);
    end

    // Abort mid-sweep with reset, then restart and poke start while busy.
    shuffle_tab();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort x0", x0, 0);
    check("abort busy0", busy0, 0);
    check("abort done0", done0, 0);
    check("abort perm0", perm0, 0);
    check("abort coll0", coll0, 0);
    check("abort fix0", fix0, 0);
    $display("reset mid-sweep applied");
    tab[3] = tab[7];
    sweep(0, "restart_ignored", 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sbox_sweep_checker.md
Name: sbox_sweep_checker

Overview:
- Sequential self-check stage that sits around the 6-bit power-map S-box.
- Upstream role: drives every input value 0..63 into the S-box input port, one per cycle.
- Downstream role: consumes the S-box output and computes bijectivity (collision count) and fixed-point count.
- Used to validate each basis/isomorphism variant of the S-box in simulation and on FPGA.

Parameters:
- WIDTH, 6: S-box word width; sweep covers 2^WIDTH inputs.
- SBOX_LAT, 0: cycles from sbox_x to valid sbox_y. 0 means a purely combinational S-box.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a sweep. Honoured only in IDLE or DONE.
- sbox_x  output  WIDTH  value driven to the S-box input.
- sbox_y  input  WIDTH  S-box output, valid SBOX_LAT cycles after sbox_x.
- busy  output  1  high during SWEEP and DRAIN.
- done  output  1  level; high in DONE until the next start or rst.
- is_perm  output  1  1 if no collisions were seen. Valid while done=1.
- collision_cnt  output  WIDTH+1  number of inputs whose output had already been produced.
- fixed_cnt  output  WIDTH+1  number of x with sbox_y==x.

Behaviour:
- One clock domain. Reset is synchronous, active-high, on clk.
- Reset values: sbox_x=0, busy=0, done=0, is_perm=0, collision_cnt=0, fixed_cnt=0, FSM=IDLE. Seen-bitmap (2^WIDTH bits) and capture pipeline are cleared.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE/DONE with start=1:
  - Next cycle enters SWEEP.
  - Clears bitmap and counters; done=0, busy=1, sbox_x=0.
  - is_perm reads 0 until DONE.
- SWEEP, issue side:
  - sbox_x increments by 1 each cycle from 0 to 2^WIDTH-1.
  - Each issued value enters an SBOX_LAT-deep tag/valid shift line.
  - With SBOX_LAT=0, capture happens in the same cycle as issue.
- SWEEP, capture side, per cycle with tag t valid:
  - If bitmap[sbox_y]=1, collision_cnt += 1; otherwise set bitmap[sbox_y].
  - If sbox_y==t, fixed_cnt += 1.
- SWEEP exit:
  - After issuing 2^WIDTH-1, go to DRAIN if SBOX_LAT>0, else DONE.
  - sbox_x holds its last value after the sweep.
- DRAIN: lasts exactly SBOX_LAT cycles, capturing the outstanding tags, then DONE.
- DONE entry (same edge): is_perm = (collision_cnt==0) using the final count; busy=0, done=1.
- Total latency from the start edge to done=1: 2^WIDTH + SBOX_LAT cycles.
- Counter range:
  - Counters never wrap: collision_cnt max is 2^WIDTH-1 and fixed_cnt max is 2^WIDTH.
  - Both fit WIDTH+1 bits.
- start while busy: ignored, no restart.
- start held high: only the first sample in IDLE/DONE matters. A new sweep starts again after DONE is reached if start is still high in the DONE state.
- rst mid-sweep: aborts on that edge, all values go to reset; bitmap contents are discarded.
- sbox_y is ignored whenever no capture tag is valid.

Optional Feature:
- Macro: SBOX_SWEEP_LUT_EN.
- Defined:
  - Adds ports lut_addr (input, WIDTH) and lut_data (output, WIDTH).
  - Each captured sbox_y is written to a 2^WIDTH-entry table at index t.
  - lut_data = table[lut_addr], registered, 1-cycle read latency; reads 0 after rst.
  - Contents are undefined while busy=1 and valid while done=1.
- Undefined: no table, no lut ports; only the counters and bitmap remain.

Test Plan:
- Identity S-box (sbox_y=sbox_x), SBOX_LAT=0, start pulse -> done at cycle 64; is_perm=1, collision_cnt=0, fixed_cnt=64.
- Constant-zero S-box -> is_perm=0, collision_cnt=63, fixed_cnt=1 (x=0).
- sbox_y = sbox_x>>1 -> collision_cnt=32, fixed_cnt=1, is_perm=0.
- sbox_y = sbox_x^6'h01 with SBOX_LAT=2 (two registers on the path) -> done at cycle 66; is_perm=1, fixed_cnt=0, collision_cnt=0.
- Real power-52 S-box (combinational) -> is_perm=1, collision_cnt=0. fixed_cnt must equal the software model's count for that basis.
- Robustness sequence:
  - Assert rst at sweep cycle 20 -> next cycle all outputs 0 and FSM IDLE.
  - Start pulse while busy at cycle 30 of a new sweep -> ignored, done still at cycle 64.
  - With SBOX_SWEEP_LUT_EN: lut_addr=5 -> lut_data=4 one cycle later, for the sbox_y=sbox_x^1 case.
